// File: rtl/lif_layer_tdm.sv
// lif_layer_tdm: a layer of NEURONS leaky-integrate-and-fire neurons sharing
// one update datapath, one neuron per clock.  Binary weights are shifted in
// a byte at a time while idle; each accepted input vector is one timestep and
// yields a spike vector over a valid/ready handshake.
//
// Build option: define REFRACTORY_EN to add per-neuron refractory counters
// (REFRACT_STEPS timesteps of suppressed input and firing after a spike).
//
// state  | meaning
// S_IDLE | accepting weight bytes or a new input vector
// S_RUN  | updating neuron r_idx this cycle
// S_OUT  | spike vector held on out_spikes until out_ready
module lif_layer_tdm #(
    parameter int INPUTS        = 8,
    parameter int NEURONS       = 4,
    parameter int U_BITS        = 8,
    parameter int REFRACT_STEPS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [7:0]          cfg_data,
    input  logic [U_BITS-1:0]   cfg_threshold,
    input  logic [2:0]          cfg_shift,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INPUTS-1:0]   in_x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NEURONS-1:0]  out_spikes
);

    localparam int SW    = NEURONS * INPUTS;
    localparam int IW    = $clog2(NEURONS);
    localparam int VW    = U_BITS + 2;
    localparam int CW    = $clog2(INPUTS + 1);
    localparam int MAX_I = (1 << (U_BITS - 1)) - 1;
    localparam int MIN_I = -(1 << (U_BITS - 1));
    localparam logic signed [VW-1:0] V_MAX = VW'(MAX_I);
    localparam logic signed [VW-1:0] V_MIN = VW'(MIN_I);
    localparam logic [IW-1:0] IDX_LAST = IW'(NEURONS - 1);

    if ((SW % 8) != 0) begin : g_bad_store
        $error("lif_layer_tdm: NEURONS*INPUTS must be a multiple of 8");
    end
    if (NEURONS < 2) begin : g_bad_neurons
        $error("lif_layer_tdm: NEURONS must be at least 2");
    end
    if (CW >= VW) begin : g_bad_width
        $error("lif_layer_tdm: INPUTS too large for the membrane datapath");
    end
    if (REFRACT_STEPS < 0) begin : g_bad_refract
        $error("lif_layer_tdm: REFRACT_STEPS must not be negative");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_accept;

    logic [SW-1:0]             r_store;
    logic [SW-1:0]             w_store_shifted;
    logic [INPUTS-1:0]         r_x;
    logic [U_BITS-1:0]         r_thr;
    logic [2:0]                r_shift;
    logic [IW-1:0]             r_idx;
    logic [NEURONS-1:0]        r_spikes;
    logic signed [U_BITS-1:0]  r_mem [NEURONS];

    logic [INPUTS-1:0]         w_weight;
    logic [CW-1:0]             w_sum;
    logic signed [U_BITS-1:0]  w_u;
    logic signed [VW-1:0]      w_u_ext;
    logic signed [VW-1:0]      w_leak;
    logic signed [VW-1:0]      w_sum_eff;
    logic signed [VW-1:0]      w_v_raw;
    logic signed [VW-1:0]      w_v_sat;
    logic signed [VW-1:0]      w_thr_ext;
    logic [U_BITS-1:0]         w_u_nxt;
    logic                      w_spike;
    logic                      w_refr;

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_spikes = r_spikes;
    assign w_accept   = in_valid && w_in_ready;

    // New weight byte enters at the bottom; the oldest byte falls off the top.
    if (SW == 8) begin : g_store_byte
        assign w_store_shifted = cfg_data;
    end else begin : g_store_wide
        assign w_store_shifted = {r_store[SW-9:0], cfg_data};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: one RUN cycle per neuron, then hold in OUT until consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_idx == IDX_LAST) w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: a weight write takes priority over a simultaneous input.
    always_comb begin
        w_in_ready  = (r_state == S_IDLE) && !cfg_we;
        w_out_valid = (r_state == S_OUT);
    end

    // Weight store and per-timestep operand latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_store <= '0;
            r_x     <= '0;
            r_thr   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE && cfg_we) r_store <= w_store_shifted;
            if (w_accept) begin
                r_x     <= in_x;
                r_thr   <= cfg_threshold;
                r_shift <= cfg_shift;
            end
        end
    end

    assign w_weight = r_store[int'(r_idx)*INPUTS +: INPUTS];
    assign w_u      = r_mem[r_idx];

    // Synaptic input of the current neuron: count of active inputs with a set weight.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < INPUTS; i++) begin
            w_sum = w_sum + CW'(w_weight[i] & r_x[i]);
        end
    end

    // Leak, integrate, saturate, fire; membrane resets by subtracting the threshold.
    always_comb begin
        w_u_ext   = {{2{w_u[U_BITS-1]}}, w_u};
        w_leak    = (r_shift == 3'd0) ? '0 : (w_u_ext >>> r_shift);
        w_sum_eff = w_refr ? '0 : signed'({{(VW-CW){1'b0}}, w_sum});
        w_v_raw   = w_u_ext - w_leak + w_sum_eff;
        if (w_v_raw > V_MAX)      w_v_sat = V_MAX;
        else if (w_v_raw < V_MIN) w_v_sat = V_MIN;
        else                      w_v_sat = w_v_raw;
        w_thr_ext = signed'({2'b00, r_thr});
        w_spike   = (w_v_sat >= w_thr_ext) && !w_refr;
        w_u_nxt   = w_spike ? (w_v_sat[U_BITS-1:0] - r_thr) : w_v_sat[U_BITS-1:0];
    end

    // Neuron index, membrane write-back and spike bit capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NEURONS; n++) r_mem[n] <= '0;
            r_idx    <= '0;
            r_spikes <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_mem[r_idx]    <= signed'(w_u_nxt);
            r_spikes[r_idx] <= w_spike;
            if (r_idx != IDX_LAST) r_idx <= r_idx + IW'(1);
        end
    end

`ifdef REFRACTORY_EN
    localparam int RW = $clog2(REFRACT_STEPS + 1);

    if (REFRACT_STEPS < 1) begin : g_bad_refract_en
        $error("lif_layer_tdm: REFRACT_STEPS must be at least 1 with refractory enabled");
    end

    logic [RW-1:0] r_refr [NEURONS];

    assign w_refr = (r_refr[r_idx] != '0);

    // Refractory counters: reload on a spike, count down one per timestep otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NEURONS; n++) r_refr[n] <= '0;
        end else if (r_state == S_RUN) begin
            if (w_spike)     r_refr[r_idx] <= RW'(REFRACT_STEPS);
            else if (w_refr) r_refr[r_idx] <= r_refr[r_idx] - RW'(1);
        end
    end
`else
    assign w_refr = 1'b0;
`endif

endmodule

// File: tb/tb_lif_layer_tdm.sv
// Directed bench for lif_layer_tdm with hand-computed expectations
// (default parameters: INPUTS=8, NEURONS=4, U_BITS=8, REFRACT_STEPS=2).
module tb_lif_layer_tdm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic [7:0] cfg_threshold = 8'd0;
    logic [2:0] cfg_shift = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_spikes;

    int n_total = 0;
    int n_bad   = 0;

    lif_layer_tdm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_data      (cfg_data),
        .cfg_threshold (cfg_threshold),
        .cfg_shift     (cfg_shift),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_spikes    (out_spikes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mem(input int n);
        logic signed [7:0] m;
        m = dut.r_mem[n];
        return int'(m);
    endfunction

    task automatic cfg_write(input logic [7:0] b);
        cfg_we   = 1'b1;
        cfg_data = b;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic run_step(input logic [7:0] x, input logic [7:0] thr,
                            input logic [2:0] sh, output logic [3:0] spk);
        int waited;
        in_x          = x;
        cfg_threshold = thr;
        cfg_shift     = sh;
        in_valid      = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("step_out_valid", int'(out_valid), 1);
        spk       = out_spikes;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s;
        int         exp_u2 [8];
        exp_u2 = '{4, 6, 7, 8, 4, 2, 1, 1};

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_spikes", int'(out_spikes), 0);
        check("rst_in_ready", int'(in_ready), 1);
        for (int n = 0; n < 4; n++) check($sformatf("rst_u%0d", n), mem(n), 0);
        rst_n = 1'b1;

        // Weights n3=FF n2=0F n1=01 n0=00
        cfg_write(8'hFF);
        cfg_write(8'h0F);
        cfg_write(8'h01);
        cfg_write(8'h00);

        // Latency and back-pressure on the first timestep
        in_x = 8'hFF; cfg_threshold = 8'd5; cfg_shift = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_run_in_ready", int'(in_ready), 0);
        check("lat_edge0_valid", int'(out_valid), 0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("lat_edge%0d_valid", i), int'(out_valid), (i == 4) ? 1 : 0);
        end
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold%0d_valid", k), int'(out_valid), 1);
            check($sformatf("hold%0d_spikes", k), int'(out_spikes), 4'b1000);
            check($sformatf("hold%0d_in_ready", k), int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
        check("t1_u3", mem(3), 3);
        check("t1_u2", mem(2), 4);
        check("t1_u1", mem(1), 1);
        check("t1_u0", mem(0), 0);

`ifdef REFRACTORY_EN
        run_step(8'hFF, 8'd5, 3'd0, s);
        check("t2_spikes", int'(s), 4'b0100);
        check("t2_u3", mem(3), 3);
        check("t2_u2", mem(2), 3);
        run_step(8'hFF, 8'd5, 3'd0, s);
        check("t3_spikes", int'(s), 4'b0000);
        check("t3_u3", mem(3), 3);
        check("t3_u1", mem(1), 3);
        run_step(8'hFF, 8'd5, 3'd0, s);
        check("t4_spikes", int'(s), 4'b1000);
        check("t4_u3", mem(3), 6);
        check("t4_u2", mem(2), 3);
        check("t4_u1", mem(1), 4);
`else
        run_step(8'hFF, 8'd5, 3'd0, s);
        check("t2_spikes", int'(s), 4'b1100);
        check("t2_u3", mem(3), 6);
        check("t2_u2", mem(2), 3);
        check("t2_u1", mem(1), 2);
        check("t2_u0", mem(0), 0);
`endif

        // Reset during RUN aborts the timestep
        in_x = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_spikes", int'(out_spikes), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_u3", mem(3), 0);
        check("midrst_u2", mem(2), 0);
        check("midrst_u0", mem(0), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("midrst_idle_valid", int'(out_valid), 0);

        // Config beats a simultaneous input; this byte becomes n2's weight
        cfg_we = 1'b1; cfg_data = 8'h0F; in_valid = 1'b1; in_x = 8'hFF;
        #1;
        check("prio_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("prio_not_accepted", int'(out_valid), 0);
        check("prio_idle_in_ready", int'(in_ready), 1);
        cfg_write(8'h00);
        cfg_write(8'h00);

        // Leak: integrate with shift 1, then decay to the floor of 1
        for (int k = 0; k < 8; k++) begin
            run_step((k < 4) ? 8'h0F : 8'h00, 8'd100, 3'd1, s);
            check($sformatf("leak%0d_spikes", k), int'(s), 0);
            check($sformatf("leak%0d_u2", k), mem(2), exp_u2[k]);
            check($sformatf("leak%0d_u3", k), mem(3), 0);
        end

        // Saturation at the top of the membrane range
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) cfg_write(8'hFF);
        for (int k = 1; k <= 16; k++) begin
            run_step(8'hFF, 8'd127, 3'd0, s);
            check($sformatf("sat%0d_spikes", k), int'(s), (k < 16) ? 0 : 15);
            check($sformatf("sat%0d_u0", k), mem(0), (k < 16) ? 8 * k : 0);
            check($sformatf("sat%0d_u3", k), mem(3), (k < 16) ? 8 * k : 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
